// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch controller: PC register, single outstanding imem read, one-entry decode buffer
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ack,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_BLOCKED = 2'd1,
        S_KILL    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;
    logic [31:0] w_target;

    assign w_target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    w_next_state = redirect ? S_FETCH : S_BLOCKED;
                end else if (redirect) begin
                    w_next_state = S_KILL;
                end
            end
            S_BLOCKED: begin
                if (redirect || inst_ack) begin
                    w_next_state = S_FETCH;
                end
            end
            S_KILL: begin
                if (imem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // r_pc is frozen while a request is outstanding, so it doubles as the in-flight address in KILL
    always_comb begin
        imem_req   = (r_state == S_FETCH) || (r_state == S_KILL);
        imem_addr  = r_pc;
        inst_valid = r_inst_valid;
        inst       = r_inst;
        inst_pc    = r_inst_pc;
        pc         = r_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_pending_pc <= 32'h0000_0000;
            r_inst       <= 32'h0000_0000;
            r_inst_pc    <= 32'h0000_0000;
            r_inst_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            r_pc         <= w_target;
                            r_inst_valid <= 1'b0;
                        end else begin
                            r_inst       <= imem_rdata;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= r_pc + 32'd4;
                        end
                    end else if (redirect) begin
                        r_pending_pc <= w_target;
                        r_inst_valid <= 1'b0;
                    end
                end
                S_BLOCKED: begin
                    if (redirect) begin
                        r_pc         <= w_target;
                        r_inst_valid <= 1'b0;
                    end else if (inst_ack) begin
                        r_inst_valid <= 1'b0;
                    end
                end
                S_KILL: begin
                    // returning data belongs to the abandoned stream; only the newest target survives
                    if (imem_ready) begin
                        r_pc <= redirect ? w_target : r_pending_pc;
                    end else if (redirect) begin
                        r_pending_pc <= w_target;
                    end
                    r_inst_valid <= 1'b0;
                end
                default: r_inst_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed plus randomized bench for fetch_ctrl against a transaction-level model
module tb_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ack;
    logic [31:0] pc;

    fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ack   (inst_ack),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: a full buffer means no request; otherwise one request is outstanding at m_pc,
    // and m_discard marks it as belonging to a stream that a redirect has abandoned.
    logic        m_valid;
    logic        m_discard;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_discard = 1'b0;
        m_pc      = RPC;
        m_pend    = 32'h0;
        m_inst    = 32'h0;
        m_inst_pc = 32'h0;
    endtask

    task automatic compare_model();
        check("req", {31'h0, imem_req}, {31'h0, !m_valid});
        if (!m_valid) check("addr", imem_addr, m_pc);
        check("valid", {31'h0, inst_valid}, {31'h0, m_valid});
        check("inst", inst, m_inst);
        check("inst_pc", inst_pc, m_inst_pc);
        check("pc", pc, m_pc);
    endtask

    task automatic cycle(input logic rd, input logic [31:0] rp, input logic rdy,
                         input logic ack, input logic [31:0] rdata);
        logic [31:0] tgt;
        compare_model();
        redirect    = rd;
        redirect_pc = rp;
        imem_ready  = rdy;
        inst_ack    = ack;
        imem_rdata  = rdata;
        tgt = rp & 32'hFFFF_FFFC;
        if (m_valid) begin
            if (rd) begin
                m_valid = 1'b0;
                m_pc    = tgt;
            end else if (ack) begin
                m_valid = 1'b0;
            end
        end else if (rdy) begin
            if (rd) begin
                m_pc = tgt;
            end else if (m_discard) begin
                m_pc = m_pend;
            end else begin
                m_inst    = rdata;
                m_inst_pc = m_pc;
                m_valid   = 1'b1;
                m_pc      = m_pc + 32'd4;
            end
            m_discard = 1'b0;
        end else if (rd) begin
            m_discard = 1'b1;
            m_pend    = tgt;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        inst_ack    = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] rp;
        rst = 1'b1;
        redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b0;
        inst_ack = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        do_reset();

        check("rst_req", {31'h0, imem_req}, 32'h1);
        check("rst_addr", imem_addr, 32'h3000);
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        cycle(0, 0, 1, 0, 32'h1111_1111);
        check("first_valid", {31'h0, inst_valid}, 32'h1);
        check("first_inst", inst, 32'h1111_1111);
        check("first_inst_pc", inst_pc, 32'h3000);
        check("first_pc", pc, 32'h3004);

        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, $urandom);
        check("bp_req", {31'h0, imem_req}, 32'h0);
        check("bp_inst", inst, 32'h1111_1111);
        cycle(0, 0, 1, 1, 32'h0);
        check("ack_req", {31'h0, imem_req}, 32'h1);
        check("ack_addr", imem_addr, 32'h3004);

        cycle(0, 0, 0, 0, 32'h0);
        cycle(1, 32'h4000, 0, 0, 32'h0);
        check("kill_addr", imem_addr, 32'h3004);
        cycle(0, 0, 0, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'hDEAD_BEEF);
        check("kill_valid", {31'h0, inst_valid}, 32'h0);
        check("kill_next", imem_addr, 32'h4000);

        cycle(1, 32'h4000, 0, 0, 32'h0);
        cycle(1, 32'h5000, 0, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h2222_2222);
        check("dbl_addr", imem_addr, 32'h5000);
        cycle(0, 0, 1, 0, 32'h3333_3333);
        check("dbl_inst_pc", inst_pc, 32'h5000);

        cycle(1, 32'h6002, 0, 1, 32'h0);
        check("rdack_valid", {31'h0, inst_valid}, 32'h0);
        check("rdack_addr", imem_addr, 32'h6000);

        cycle(1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h4444_4444);
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_pc", pc, 32'h0);
        cycle(0, 0, 0, 1, 32'h0);
        cycle(0, 0, 0, 0, 32'h0);
        do_reset();
        check("midrst_valid", {31'h0, inst_valid}, 32'h0);
        check("midrst_addr", imem_addr, 32'h3000);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC | $urandom_range(0, 3) : $urandom;
                cycle($urandom_range(0, 5) == 0, rp, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom);
            end
        end
        compare_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
